// File: rtl/irq_edge_capture.sv
// Interrupt front-end for KCPSM3: synchronises async lines, latches rising edges
// as pending flags, exposes mask/status/clear/raw on the I/O bus and runs the handshake.
module irq_edge_capture #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  STATUS_ADDR = 8'h10,
  parameter logic [7:0]  MASK_ADDR   = 8'h11,
  parameter logic [7:0]  CLEAR_ADDR  = 8'h12,
  parameter logic [7:0]  RAW_ADDR    = 8'h13
) (
  input  logic             C,
  input  logic             CLR,
  input  logic [WIDTH-1:0] din,
  input  logic [7:0]       port_id,
  input  logic             write_strobe,
  input  logic             read_strobe,
  input  logic [7:0]       out_port,
  output logic [7:0]       in_port,
  output logic             interrupt,
  input  logic             interrupt_ack
);

  localparam int unsigned BUS_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] clr_mask;
  logic [BUS_W-1:0] rd_data;
  logic             wr_clear;
  logic             wr_mask;
  logic             req;
  logic             irq_next;
  state_t           state;
  state_t           next_state;

  // Reads are non-destructive, so the read qualifier carries no function here.
  logic unused_ok;
  assign unused_ok = ^{read_strobe, out_port};

  // Metastability chain; only the last stage is ever consumed.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= din;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s        = sync_q[SYNC_STAGES-1];
  assign edge_det = s & ~prev;
  assign wr_clear = write_strobe && (port_id == CLEAR_ADDR);
  assign wr_mask  = write_strobe && (port_id == MASK_ADDR);
  assign clr_mask = wr_clear ? out_port[WIDTH-1:0] : '0;
  assign req      = |(pending & mask);

  always_comb begin
    rd_data = '0;
    if (port_id == STATUS_ADDR) begin
      rd_data = BUS_W'(pending);
    end else if (port_id == MASK_ADDR) begin
      rd_data = BUS_W'(mask);
    end else if (port_id == RAW_ADDR) begin
      rd_data = BUS_W'(s);
    end
  end

  // A new edge beats a same-cycle clear so no event is ever dropped.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      prev    <= '0;
      pending <= '0;
      mask    <= '0;
      in_port <= '0;
    end else begin
      prev    <= s;
      pending <= (pending & ~clr_mask) | edge_det;
      if (wr_mask) begin
        mask <= out_port[WIDTH-1:0];
      end
      in_port <= rd_data;
    end
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state     <= IDLE;
      interrupt <= 1'b0;
    end else begin
      state     <= next_state;
      interrupt <= irq_next;
    end
  end

  // SERVICE waits for software to touch clear/mask before a re-raise is allowed.
  always_comb begin
    next_state = state;
    irq_next   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          next_state = REQ;
        end
      end
      REQ: begin
        if (interrupt_ack) begin
          next_state = SERVICE;
        end else if (!req) begin
          next_state = IDLE;
        end
      end
      SERVICE: begin
        if (wr_clear || wr_mask || !req) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    irq_next = (next_state == REQ);
  end

endmodule

// File: tb/tb_irq_edge_capture.sv
// Self-checking bench for irq_edge_capture: directed scenarios plus randomized
// traffic, all checked against a cycle-level behavioural model of the block.
module tb_irq_edge_capture;

  localparam int unsigned W = 8;
  localparam int unsigned S = 2;
  localparam logic [7:0] STATUS = 8'h10;
  localparam logic [7:0] MASK   = 8'h11;
  localparam logic [7:0] CLEAR  = 8'h12;
  localparam logic [7:0] RAW    = 8'h13;

  localparam int PH_IDLE     = 0;
  localparam int PH_WAIT_ACK = 1;
  localparam int PH_SERVED   = 2;

  logic         C;
  logic         CLR;
  logic [W-1:0] din;
  logic [7:0]   port_id;
  logic         write_strobe;
  logic         read_strobe;
  logic [7:0]   out_port;
  logic [7:0]   in_port;
  logic         interrupt;
  logic         interrupt_ack;

  int n_tests = 0;
  int n_fail  = 0;

  irq_edge_capture #(
    .WIDTH(W), .SYNC_STAGES(S), .STATUS_ADDR(STATUS),
    .MASK_ADDR(MASK), .CLEAR_ADDR(CLEAR), .RAW_ADDR(RAW)
  ) dut (
    .C(C), .CLR(CLR), .din(din), .port_id(port_id),
    .write_strobe(write_strobe), .read_strobe(read_strobe),
    .out_port(out_port), .in_port(in_port),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack)
  );

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  // Behavioural model: din seen through an S-deep delay line, edge = rise of that view.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_s, m_prev, m_pend, m_mask;
  logic [7:0]   m_inport;
  logic         m_irq;
  int           m_phase;

  task automatic model_reset();
    hist.delete();
    m_s = '0; m_prev = '0; m_pend = '0; m_mask = '0;
    m_inport = '0; m_irq = 1'b0; m_phase = PH_IDLE;
  endtask

  task automatic model_edge(input logic [7:0] pid, input logic ws, input logic [7:0] od,
                            input logic ack, input logic [W-1:0] dn);
    logic [W-1:0] rise;
    logic [W-1:0] clr;
    logic         want;
    logic         touch;
    rise  = m_s & ~m_prev;
    want  = (m_pend & m_mask) != '0;
    clr   = (ws && pid == CLEAR) ? od[W-1:0] : '0;
    touch = ws && (pid == CLEAR || pid == MASK);
    if (pid == STATUS) m_inport = 8'(m_pend);
    else if (pid == MASK) m_inport = 8'(m_mask);
    else if (pid == RAW) m_inport = 8'(m_s);
    else m_inport = 8'h00;
    if (m_phase == PH_IDLE && want) m_phase = PH_WAIT_ACK;
    else if (m_phase == PH_WAIT_ACK && ack) m_phase = PH_SERVED;
    else if (m_phase == PH_WAIT_ACK && !want) m_phase = PH_IDLE;
    else if (m_phase == PH_SERVED && (touch || !want)) m_phase = PH_IDLE;
    m_irq  = (m_phase == PH_WAIT_ACK);
    m_pend = (m_pend & ~clr) | rise;
    if (ws && pid == MASK) m_mask = od[W-1:0];
    m_prev = m_s;
    hist.push_front(dn);
    if (hist.size() > S) void'(hist.pop_back());
    m_s = (hist.size() >= S) ? hist[S-1] : '0;
  endtask

  task automatic step();
    logic [7:0]   pid;
    logic         ws;
    logic [7:0]   od;
    logic         ack;
    logic [W-1:0] dn;
    pid = port_id; ws = write_strobe; od = out_port; ack = interrupt_ack; dn = din;
    @(posedge C);
    model_edge(pid, ws, od, ack, dn);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_id = a; out_port = d; write_strobe = 1'b1;
    step();
    write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    port_id = a; read_strobe = 1'b1;
    step();
    read_strobe = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", interrupt); end
    n_tests++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL reset_in_port: got %h expected 00", in_port); end
    model_reset();
    #2 CLR = 1'b0;
    rd(STATUS);
    n_tests++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h expected 00", in_port); end
  endtask

  task automatic test_reset_midrun();
    wr(MASK, 8'hFF);
    din = 8'hFF;
    repeat (4) step();
    n_tests++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL midrun_pre_irq: got %b expected 1", interrupt); end
    n_tests++; if (in_port !== 8'hFF) begin n_fail++; $display("FAIL midrun_pre_mask: got %h expected ff", in_port); end
    CLR = 1'b1; din = '0;
    #1;
    n_tests++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL midrun_async_irq: got %b expected 0", interrupt); end
    n_tests++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL midrun_async_in_port: got %h expected 00", in_port); end
    model_reset();
    #2 CLR = 1'b0;
    rd(STATUS);
    n_tests++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL midrun_status: got %h expected 00", in_port); end
    rd(MASK);
    n_tests++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL midrun_mask: got %h expected 00", in_port); end
    n_tests++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL midrun_irq_after: got %b expected 0", interrupt); end
  endtask

  task automatic test_edge_latency();
    wr(MASK, 8'h01);
    port_id = STATUS; din = '0;
    repeat (3) step();
    din[0] = 1'b1;
    step();
    n_tests++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL latency_k_irq: got %b expected 0", interrupt); end
    step();
    n_tests++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL latency_k1_status: got %h expected 00", in_port); end
    step();
    n_tests++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL latency_k2_irq: got %b expected 0", interrupt); end
    step();
    n_tests++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL latency_k3_irq: got %b expected 1", interrupt); end
    n_tests++; if (in_port !== 8'h01) begin n_fail++; $display("FAIL latency_k3_status: got %h expected 01", in_port); end
    interrupt_ack = 1'b1;
    step();
    interrupt_ack = 1'b0;
    n_tests++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL latency_ack_irq: got %b expected 0", interrupt); end
    wr(CLEAR, 8'h01);
    port_id = STATUS;
    repeat (4) step();
    n_tests++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL latency_held_high_status: got %h expected 00", in_port); end
    n_tests++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL latency_held_high_irq: got %b expected 0", interrupt); end
  endtask

  task automatic test_handshake();
    din[0] = 1'b0;
    repeat (3) step();
    din[0] = 1'b1;
    repeat (4) step();
    n_tests++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL hs_raise: got %b expected 1", interrupt); end
    interrupt_ack = 1'b1;
    step();
    interrupt_ack = 1'b0;
    n_tests++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL hs_ack_drop: got %b expected 0", interrupt); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL hs_service_hold %0d: got %b expected 0", i, interrupt); end
    end
    wr(CLEAR, 8'h01);
    n_tests++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL hs_clear_irq: got %b expected 0", interrupt); end
    rd(STATUS);
    n_tests++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL hs_idle_irq: got %b expected 0", interrupt); end
    n_tests++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL hs_status: got %h expected 00", in_port); end
    din[0] = 1'b0;
    repeat (2) step();
    din[0] = 1'b1;
    repeat (4) step();
    n_tests++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL hs_reraise: got %b expected 1", interrupt); end
    interrupt_ack = 1'b1;
    step();
    interrupt_ack = 1'b0;
    wr(CLEAR, 8'hFF);
  endtask

  task automatic test_masking();
    wr(MASK, 8'h00);
    din = '0;
    repeat (3) step();
    wr(CLEAR, 8'hFF);
    din = 8'h28;
    repeat (4) step();
    rd(STATUS);
    n_tests++; if (in_port !== 8'h28) begin n_fail++; $display("FAIL mask_status: got %h expected 28", in_port); end
    n_tests++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL mask_irq_masked: got %b expected 0", interrupt); end
    wr(MASK, 8'h08);
    n_tests++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL mask_irq_at_write: got %b expected 0", interrupt); end
    step();
    n_tests++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL mask_irq_unmasked: got %b expected 1", interrupt); end
    wr(MASK, 8'h00);
    n_tests++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL mask_drop_at_write: got %b expected 1", interrupt); end
    step();
    n_tests++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL mask_drop_after: got %b expected 0", interrupt); end
    wr(MASK, 8'h08);
    step();
    n_tests++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL mask_reraise: got %b expected 1", interrupt); end
    // ack and a partial clear land together: ack wins, clear still lands
    port_id = CLEAR; out_port = 8'h08; write_strobe = 1'b1; interrupt_ack = 1'b1;
    step();
    write_strobe = 1'b0; interrupt_ack = 1'b0;
    n_tests++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL ack_clear_irq: got %b expected 0", interrupt); end
    rd(STATUS);
    n_tests++; if (in_port !== 8'h20) begin n_fail++; $display("FAIL ack_clear_status: got %h expected 20", in_port); end
    n_tests++; if (interrupt !== m_irq) begin n_fail++; $display("FAIL ack_clear_model_irq: got %b expected %b", interrupt, m_irq); end
    wr(CLEAR, 8'hFF);
  endtask

  task automatic test_collision();
    wr(MASK, 8'h00);
    din = '0;
    repeat (3) step();
    wr(CLEAR, 8'hFF);
    wr(CLEAR, 8'h04);
    rd(STATUS);
    n_tests++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL coll_plain_clear: got %h expected 00", in_port); end
    din[2] = 1'b1;
    repeat (4) step();
    din[2] = 1'b0;
    repeat (3) step();
    din[2] = 1'b1;
    step();
    step();
    wr(CLEAR, 8'h04);
    rd(STATUS);
    n_tests++; if (in_port !== 8'h04) begin n_fail++; $display("FAIL coll_set_wins: got %h expected 04", in_port); end
    n_tests++; if (in_port !== m_inport) begin n_fail++; $display("FAIL coll_model: got %h expected %h", in_port, m_inport); end
    wr(CLEAR, 8'hFF);
  endtask

  task automatic test_falling_raw();
    logic [W-1:0] dq[$];
    din = 8'h02;
    repeat (4) step();
    wr(CLEAR, 8'hFF);
    repeat (2) step();
    din[1] = 1'b0;
    repeat (4) step();
    rd(STATUS);
    n_tests++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL falling_status: got %h expected 00", in_port); end
    din = '0;
    port_id = RAW;
    repeat (3) step();
    dq.push_front('0);
    dq.push_front('0);
    for (int i = 0; i < 12; i++) begin
      din = W'($urandom);
      dq.push_front(din);
      step();
      n_tests++; if (in_port !== 8'(dq[2])) begin n_fail++; $display("FAIL raw_track %0d: got %h expected %h", i, in_port, dq[2]); end
    end
    port_id = 8'h20;
    step();
    n_tests++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL unmapped_read: got %h expected 00", in_port); end
    wr(8'h20, 8'hFF);
    rd(MASK);
    n_tests++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL unmapped_write: got %h expected 00", in_port); end
    din = '0;
    repeat (3) step();
    wr(CLEAR, 8'hFF);
  endtask

  task automatic test_random();
    logic [7:0] addrs [6];
    addrs[0] = STATUS; addrs[1] = MASK; addrs[2] = CLEAR;
    addrs[3] = RAW; addrs[4] = 8'h20; addrs[5] = 8'h00;
    for (int i = 0; i < 400; i++) begin
      din           = din ^ W'($urandom & $urandom & $urandom);
      port_id       = addrs[$urandom_range(0, 5)];
      out_port      = 8'($urandom);
      write_strobe  = ($urandom_range(0, 9) < 2);
      interrupt_ack = ($urandom_range(0, 3) == 0);
      step();
      n_tests++; if (in_port !== m_inport) begin n_fail++; $display("FAIL random_in_port %0d: got %h expected %h", i, in_port, m_inport); end
      n_tests++; if (interrupt !== m_irq) begin n_fail++; $display("FAIL random_irq %0d: got %b expected %b", i, interrupt, m_irq); end
    end
    write_strobe = 1'b0;
    interrupt_ack = 1'b0;
  endtask

  initial begin
    CLR = 1'b1; din = '0; port_id = 8'h00; write_strobe = 1'b0;
    read_strobe = 1'b0; out_port = 8'h00; interrupt_ack = 1'b0;
    model_reset();
    test_reset();
    test_reset_midrun();
    test_edge_latency();
    test_handshake();
    test_masking();
    test_collision();
    test_falling_raw();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
